// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the execute stage.
//   ALU_* : 4-bit ALU operation codes carried in id_ex_alu_op
//   MUL_CYCLES : shift-add iterations of the optional multiplier
//   mul_state_t : multiplier sequencer states
package ex_pkg;
   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_SLT = 4'd5;
   localparam logic [3:0] ALU_SLL = 4'd6;
   localparam logic [3:0] ALU_SRL = 4'd7;
   localparam logic [3:0] ALU_MUL = 4'd8;
   localparam int MUL_CYCLES = 32;
   typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_t;
endpackage

// File: rtl/ex_mul_iter.sv
// ex_mul_iter: iterative shift-add multiplier producing the low XLEN bits of a*b.
//   clk, rst      : clock, synchronous active-high reset (aborts a running multiply)
//   start         : accept a and b while idle
//   a, b          : operands
//   busy          : high during the MUL_CYCLES shift-add cycles
//   done          : high for the single cycle after the last iteration; product valid
//   product       : accumulated result
module ex_mul_iter
   import ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] product
);
   localparam int CW = $clog2(MUL_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);
   mul_state_t state, next;
   logic [CW-1:0] count;
   logic [XLEN-1:0] ma, mb;
   assign busy = state == MUL_BUSY;
   assign done = state == MUL_DONE;
   always_ff @(posedge clk)
      state <= rst ? MUL_IDLE : next;
   always_comb begin
      next = state;
      next = state == MUL_IDLE ? (start ? MUL_BUSY : MUL_IDLE)
           : state == MUL_BUSY ? (count == LAST ? MUL_DONE : MUL_BUSY)
           : MUL_IDLE;
   end
   // multiplicand shifts left, multiplier shifts right: bit 0 of mb selects each partial product
   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         ma      <= '0;
         mb      <= '0;
         product <= '0;
      end else if (state == MUL_IDLE && start) begin
         count   <= '0;
         ma      <= a;
         mb      <= b;
         product <= '0;
      end else if (state == MUL_BUSY) begin
         product <= product + (mb[0] ? ma : '0);
         ma      <= ma << 1;
         mb      <= mb >> 1;
         count   <= count + 1'b1;
      end
   end
endmodule

// File: rtl/execute.sv
// execute: EX stage - ALU, BEQ resolution and EX/MEM pipeline register.
//   clk, rst        : clock, synchronous active-high reset
//   id_ex_*         : ID/EX register contents (operands, immediate, rd, op, controls)
//   ex_mem_*        : registered EX/MEM contents; pc_src/npc redirect fetch
//   ex_flush        : equals ex_mem_pc_src; kills IF/ID and ID/EX
//   ex_stall        : combinational freeze of PC, IF/ID, ID/EX while multiplying
// Build option: EXECUTE_MUL_EN enables the iterative multiplier for op 8;
// without it op 8 yields 0 in one cycle and ex_stall is tied low.
module execute
   import ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_ex_valid,
   input  logic [XLEN-1:0] id_ex_npc,
   input  logic [XLEN-1:0] id_ex_rs_val,
   input  logic [XLEN-1:0] id_ex_rt_val,
   input  logic [XLEN-1:0] id_ex_imm,
   input  logic [4:0]      id_ex_rd,
   input  logic [3:0]      id_ex_alu_op,
   input  logic            id_ex_alu_src,
   input  logic            id_ex_branch,
   input  logic            id_ex_mem_read,
   input  logic            id_ex_mem_write,
   input  logic            id_ex_reg_write,
   output logic            ex_mem_valid,
   output logic            ex_mem_mem_read,
   output logic            ex_mem_mem_write,
   output logic            ex_mem_reg_write,
   output logic            ex_mem_zero,
   output logic [XLEN-1:0] ex_mem_alu_result,
   output logic [XLEN-1:0] ex_mem_rt_val,
   output logic [4:0]      ex_mem_rd,
   output logic            ex_mem_pc_src,
   output logic [XLEN-1:0] ex_mem_npc,
   output logic            ex_flush,
   output logic            ex_stall
);
   logic [XLEN-1:0] b_op, diff, alu_result, result;
   logic [4:0] shamt;
   logic zero, kill;
   assign b_op  = id_ex_alu_src ? id_ex_imm : id_ex_rt_val;
   assign diff  = id_ex_rs_val - b_op;
   assign zero  = diff == '0;
   assign shamt = id_ex_imm[10:6];
   always_comb begin
      alu_result = '0;
      case (id_ex_alu_op)
         ALU_ADD: alu_result = id_ex_rs_val + b_op;
         ALU_SUB: alu_result = diff;
         ALU_AND: alu_result = id_ex_rs_val & b_op;
         ALU_OR:  alu_result = id_ex_rs_val | b_op;
         ALU_XOR: alu_result = id_ex_rs_val ^ b_op;
         ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, $signed(id_ex_rs_val) < $signed(b_op)};
         ALU_SLL: alu_result = id_ex_rs_val << shamt;
         ALU_SRL: alu_result = id_ex_rs_val >> shamt;
         default: alu_result = '0;
      endcase
   end
`ifdef EXECUTE_MUL_EN
   logic mul_start, mul_busy, mul_done;
   logic [XLEN-1:0] mul_product;
   // a squashed MUL must not start; DONE still sees the held MUL in ID/EX, so gate on idle
   assign mul_start = ~rst & id_ex_valid & ~ex_mem_pc_src & (id_ex_alu_op == ALU_MUL)
                    & ~mul_busy & ~mul_done;
   assign ex_stall  = ~rst & (mul_start | mul_busy);
   assign result    = mul_done ? mul_product : alu_result;
   ex_mul_iter #(.XLEN(XLEN)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (id_ex_rs_val),
      .b       (b_op),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );
`else
   assign ex_stall = 1'b0;
   assign result   = alu_result;
`endif
   // wrong-path, empty and stalled slots all load a fully zeroed bubble
   assign kill     = ~id_ex_valid | ex_mem_pc_src | ex_stall;
   assign ex_flush = ex_mem_pc_src;
   always_ff @(posedge clk) begin
      if (rst || kill) begin
         ex_mem_valid      <= 1'b0;
         ex_mem_mem_read   <= 1'b0;
         ex_mem_mem_write  <= 1'b0;
         ex_mem_reg_write  <= 1'b0;
         ex_mem_zero       <= 1'b0;
         ex_mem_alu_result <= '0;
         ex_mem_rt_val     <= '0;
         ex_mem_rd         <= '0;
         ex_mem_pc_src     <= 1'b0;
         ex_mem_npc        <= '0;
      end else begin
         ex_mem_valid      <= 1'b1;
         ex_mem_mem_read   <= id_ex_mem_read;
         ex_mem_mem_write  <= id_ex_mem_write;
         ex_mem_reg_write  <= id_ex_reg_write;
         ex_mem_zero       <= zero;
         ex_mem_alu_result <= result;
         ex_mem_rt_val     <= id_ex_rt_val;
         ex_mem_rd         <= id_ex_rd;
         ex_mem_pc_src     <= id_ex_branch & zero;
         ex_mem_npc        <= id_ex_npc + (id_ex_imm << 2);
      end
   end
endmodule
